sseg_scan_mux: RTL
==================

SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, meaning number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DWELL, default 100000, meaning clk cycles each digit is lit (>=1).
REQ-003 SHALL have parameter BLANK, default 1000, meaning clk cycles all anodes are off between digits (>=1).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: load  input  1  one-cycle request to display data_in/dp_in.
REQ-007 Port: data_in  input  4*N_DIGITS  nibble k = digit k (digit 0 rightmost).
REQ-008 Port: dp_in  input  N_DIGITS  decimal point per digit, 1 = lit.
REQ-009 Port: lz_blank  input  1  1 = suppress leading zeros.
REQ-010 Port: hex_out  output  4  nibble for the downstream hex-to-segment decoder.
REQ-011 Port: hex_en  output  1  enable for the downstream decoder; 0 = blank segments.
REQ-012 Port: an_n  output  N_DIGITS  digit anodes, active-low, at most one low.
REQ-013 Port: dp_n  output  1  decimal point, active-low.
REQ-014 Port: load_ack  output  1  one-cycle pulse when a pending load becomes active.
REQ-015 Port: frame_tick  output  1  one-cycle pulse at each wrap from last digit to digit 0.

Function
REQ-016 SHALL hold a shadow register (data, dp, pending flag) and an active register; load=1 writes shadow and sets pending.
REQ-017 A load while pending SHALL overwrite the shadow; only the newest value becomes active; one load_ack for the merged pair.
REQ-018 Shadow-to-active transfer SHALL occur only on the cycle the scanner wraps to digit 0 (same cycle as frame_tick), clearing pending and pulsing load_ack there; no tearing within a frame.
REQ-019 Load coincident with the wrap cycle SHALL be transferred at that wrap and acknowledged.
REQ-020 FSM states: SHOW, GAP; SHOW counts DWELL cycles, then GAP; GAP counts BLANK cycles, then advances digit index and returns to SHOW.
REQ-021 Digit index SHALL increment 0..N_DIGITS-1 and wrap to 0; frame_tick pulses on the GAP->SHOW transition that wraps.
REQ-022 In SHOW, an_n SHALL be low only at the current index; hex_out = active nibble; dp_n = ~active dp bit.
REQ-023 In GAP, an_n SHALL be all ones, hex_en = 0, dp_n = 1.
REQ-024 hex_en in SHOW SHALL be 1, except when lz_blank=1, digit index >0, and all active nibbles at index and above are zero; then hex_en=0 (dp unaffected); digit 0 always enabled.
REQ-025 All outputs SHALL be registered; outputs reflect state/index with exactly one clk latency.
REQ-026 Dwell counter SHALL be $clog2(max(DWELL,BLANK)) bits, reset to 0 on every state change; no overflow.

Reset
REQ-027 While rst_n=0: state SHOW, index 0, counters 0, active/shadow data 0, dp 0, pending 0.
REQ-028 Reset outputs: an_n all ones, hex_out 0, hex_en 0, dp_n 1, load_ack 0, frame_tick 0.
REQ-029 Reset mid-frame or with a pending load SHALL discard the pending load with no load_ack.
REQ-030 First cycle after rst_n release SHALL begin SHOW of digit 0 with a full DWELL count.

Structure
REQ-031 FSM state encoding and default DWELL/BLANK constants SHALL live in the shared display package.
REQ-032 Leading-zero mask generation SHALL be a sub-module lz_mask (combinational, N_DIGITS nibbles in, N_DIGITS enable bits out).
REQ-033 Decoder SHALL NOT be instantiated inside; hex_out/hex_en feed it externally.

Verification (N_DIGITS=4, DWELL=4, BLANK=2)
REQ-034 Reset release, no load -> an_n cycles 1110,1111,1101,...; each low 4 cycles, all-high 2; frame_tick every 24 cycles.
REQ-035 load data_in=16'h12AF mid-frame -> display unchanged until wrap; load_ack and frame_tick same cycle; digit 0 then shows hex_out=F.
REQ-036 Two loads (16'h1111 then 16'h2222) in one frame -> single load_ack; 16'h2222 shown next frame.
REQ-037 lz_blank=1, data 16'h0050 -> hex_en 1 on digits 0,1; 0 on digits 2,3; data 16'h0000 -> only digit 0 enabled.
REQ-038 dp_in=4'b0100 -> dp_n=0 only while an_n=1011 in SHOW; 1 during GAP.
REQ-039 rst_n low with load pending mid-frame -> outputs go to reset values asynchronously; no load_ack after release; display shows 0000.

Source files
------------

// File: rtl/sseg_scan_mux_pkg.sv
// Shared display package: scanner state encoding, default timing constants
// and a helper for sizing the dwell/blank counter.
package sseg_scan_mux_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    localparam int unsigned DEF_DWELL = 100000;
    localparam int unsigned DEF_BLANK = 1000;

    // Counter width able to count 0..max(dwell,blank)-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
        int unsigned m;
        m = (dwell > blank) ? dwell : blank;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sseg_scan_mux_lz_mask.sv
// Leading-zero mask: en[k] is 1 when digit k is 0 or any nibble at k or above
// is non-zero, i.e. the digit is not a leading zero.
module lz_mask
    import sseg_scan_mux_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8
) (
    input  logic [4*N_DIGITS-1:0] nibbles,
    output logic [N_DIGITS-1:0]   en
);

    logic zero_run;

    // Walk from the most significant digit down, tracking whether everything seen so far is zero.
    always_comb begin
        zero_run = 1'b1;
        en       = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            zero_run = zero_run & (nibbles[4*(N_DIGITS-1-i) +: 4] == 4'h0);
            en[N_DIGITS-1-i] = ((N_DIGITS-1-i) == 0) | ~zero_run;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Multiplexed seven-segment scanner: cycles the digit anodes with a dwell
// period and an all-off blanking gap, double-buffers display data so new
// values only take effect at a frame boundary, and optionally blanks
// leading zeros. Segment decoding is done downstream from hex_out/hex_en.
module sseg_scan_mux
    import sseg_scan_mux_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned DWELL    = DEF_DWELL,
    parameter int unsigned BLANK    = DEF_BLANK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [3:0]            hex_out,
    output logic                  hex_en,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  dp_n,
    output logic                  load_ack,
    output logic                  frame_tick
);

    localparam int unsigned CW = cnt_width(DWELL, BLANK);
    localparam int unsigned IW = $clog2(N_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    scan_state_t           state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  pending;
    logic [4*N_DIGITS-1:0] active_data;
    logic [N_DIGITS-1:0]   active_dp;

    logic [N_DIGITS-1:0]   lz_en;
    logic                  wrap;
    logic [N_DIGITS-1:0]   an_sel_n;
    logic [3:0]            cur_nib;

    lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .nibbles (active_data),
        .en      (lz_en)
    );

    // Wrap happens on the last blank cycle of the last digit.
    always_comb begin
        wrap     = (state == GAP) && (cnt == BLANK_LAST) && (idx == IDX_LAST);
        cur_nib  = active_data[{idx, 2'b00} +: 4];
        an_sel_n = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            an_sel_n[k] = (idx != IW'(k));
        end
    end

    // Scanner FSM: SHOW for DWELL cycles, GAP for BLANK cycles, then next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SHOW;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SHOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Shadow/active buffering; a load on the wrap cycle bypasses the shadow so it is taken immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            active_data <= '0;
            active_dp   <= '0;
            load_ack    <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_tick <= wrap;
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    active_data <= data_in;
                    active_dp   <= dp_in;
                    load_ack    <= 1'b1;
                end else if (pending) begin
                    active_data <= shadow_data;
                    active_dp   <= shadow_dp;
                    load_ack    <= 1'b1;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scanner state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n    <= '1;
            hex_out <= '0;
            hex_en  <= 1'b0;
            dp_n    <= 1'b1;
        end else if (state == SHOW) begin
            an_n    <= an_sel_n;
            hex_out <= cur_nib;
            hex_en  <= ~lz_blank | lz_en[idx];
            dp_n    <= ~active_dp[idx];
        end else begin
            an_n    <= '1;
            hex_out <= '0;
            hex_en  <= 1'b0;
            dp_n    <= 1'b1;
        end
    end

endmodule
